// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MAR/MDR memory access controller.
package mem_ctrl_pkg;

  localparam int unsigned DW_DEFAULT   = 16;
  localparam int unsigned MEM_WAIT_MAX = 15;
  localparam int unsigned WAIT_CW      = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    MAR,
    WAIT,
    MDR,
    XFER
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester ports plus shared-bus and memory strobe signals of the controller.
interface mem_access_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          req0;
  logic          we0;
  logic [DW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          req1;
  logic          we1;
  logic [DW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          ld_mar;
  logic          ld_mdr;
  logic          sel_mdr;
  logic          mem_we;
  logic          ena_mdr;
  logic          busy;

  // Requesters and the bus/memory environment
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_in,
    input  ack0, ack1, rdata, bus_out, bus_oe,
    input  ld_mar, ld_mdr, sel_mdr, mem_we, ena_mdr, busy
  );

  // The controller itself
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_in,
    output ack0, ack1, rdata, bus_out, bus_oe,
    output ld_mar, ld_mdr, sel_mdr, mem_we, ena_mdr, busy
  );
endinterface

// File: rtl/mem_access_ctrl_rr_arbiter2.sv
// Two-request round-robin arbiter; the port not served last wins a tie.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] grant
);

  port_t last_q;

  // One-hot grant; ties go to the port that was not served last
  always_comb begin
    grant = '0;
    if (en) begin
      if (req0 && req1) begin
        grant = (last_q == PORT1) ? 2'b01 : 2'b10;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end

  // Last-served pointer; reset value makes port 0 win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT1;
    end else if (grant[0]) begin
      last_q <= PORT0;
    end else if (grant[1]) begin
      last_q <= PORT1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Two-port sequencer for the MAR/MDR datapath; strobes decode from registered state only.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  mif
);

  localparam logic [WAIT_CW-1:0] WAIT_LOAD =
    WAIT_CW'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  state_t               state_q;
  state_t               state_nx;
  port_t                sel_q;
  logic                 we_q;
  logic [DW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [DW-1:0]        rdata_q;
  logic [WAIT_CW-1:0]   wait_cnt_q;
  logic [1:0]           grant;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == IDLE),
    .req0  (mif.req0),
    .req1  (mif.req1),
    .grant (grant)
  );

  // State, latched transaction, wait counter and read-data holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= PORT0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == IDLE && grant != 2'b00) begin
        sel_q   <= grant[1] ? PORT1 : PORT0;
        we_q    <= grant[1] ? mif.we1    : mif.we0;
        addr_q  <= grant[1] ? mif.addr1  : mif.addr0;
        wdata_q <= grant[1] ? mif.wdata1 : mif.wdata0;
      end
      if (state_q == MAR) begin
        wait_cnt_q <= WAIT_LOAD;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end
      if (state_q == XFER && !we_q) begin
        rdata_q <= mif.bus_in;
      end
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE: if (grant != 2'b00) state_nx = MAR;
      MAR:  state_nx = (MEM_WAIT > 0) ? WAIT : MDR;
      WAIT: if (wait_cnt_q == '0) state_nx = MDR;
      MDR:  state_nx = XFER;
      XFER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore decode of bus drive, strobes and acks
  always_comb begin
    mif.bus_oe  = 1'b0;
    mif.bus_out = '0;
    mif.ld_mar  = 1'b0;
    mif.ld_mdr  = 1'b0;
    mif.sel_mdr = 1'b0;
    mif.mem_we  = 1'b0;
    mif.ena_mdr = 1'b0;
    mif.ack0    = 1'b0;
    mif.ack1    = 1'b0;
    unique case (state_q)
      MAR: begin
        mif.bus_oe  = 1'b1;
        mif.bus_out = addr_q;
        mif.ld_mar  = 1'b1;
      end
      MDR: begin
        mif.ld_mdr = 1'b1;
        if (we_q) begin
          mif.bus_oe  = 1'b1;
          mif.bus_out = wdata_q;
        end else begin
          mif.sel_mdr = 1'b1;
        end
      end
      XFER: begin
        mif.mem_we  = we_q;
        mif.ena_mdr = !we_q;
        mif.ack0    = (sel_q == PORT0);
        mif.ack1    = (sel_q == PORT1);
      end
      default: ;
    endcase
  end

  // rdata is passed straight from the bus during a read's ack cycle so it is
  // valid there, and the holding register covers every later cycle.
  assign mif.rdata = (state_q == XFER && !we_q) ? mif.bus_in : rdata_q;
  assign mif.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: scenario tasks plus randomized traffic against a transaction-level model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DW(16)) ifa ();
  mem_access_ctrl_if #(.DW(16)) ifb ();

  mem_access_ctrl #(.DW(16), .MEM_WAIT(0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .mif   (ifa)
  );

  mem_access_ctrl #(.DW(16), .MEM_WAIT(3)) u_dut_w (
    .clk   (clk),
    .reset (reset),
    .mif   (ifb)
  );

  int checks   = 0;
  int failures = 0;

  // Memory datapath environment for DUT A: MAR, MDR and a 256-word memory
  logic [15:0] env_mem [256];
  logic [15:0] env_mar;
  logic [15:0] env_mdr;
  logic        mem_init = 1'b0;

  function automatic logic [15:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 16) ? 16'hBEEF : {b ^ 8'hC3, b};
  endfunction

  assign ifa.bus_in = ifa.bus_oe ? ifa.bus_out : (ifa.ena_mdr ? env_mdr : 16'h0000);
  assign ifb.bus_in = ifb.bus_oe ? ifb.bus_out : 16'hA5C3;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else begin
      if (ifa.ld_mar) env_mar <= ifa.bus_in;
      if (ifa.ld_mdr) env_mdr <= ifa.sel_mdr ? env_mem[env_mar[7:0]] : ifa.bus_in;
      if (ifa.mem_we) env_mem[env_mar[7:0]] <= env_mdr;
    end
  end

  // Transaction-level reference model
  logic [15:0] ref_mem [256];
  int          last_served;

  task automatic tick();
    @(negedge clk);
    checks++;
    if ((ifa.ack0 && ifa.ack1) || (ifb.ack0 && ifb.ack1)) begin
      failures++;
      $display("FAIL ack_exclusive: a0=%b a1=%b b0=%b b1=%b required not both", ifa.ack0, ifa.ack1, ifb.ack0, ifb.ack1);
    end
    checks++;
    if ((ifa.bus_oe && ifa.ena_mdr) || (ifb.bus_oe && ifb.ena_mdr)) begin
      failures++;
      $display("FAIL oe_vs_ena: a_oe=%b a_ena=%b b_oe=%b b_ena=%b required not both", ifa.bus_oe, ifa.ena_mdr, ifb.bus_oe, ifb.ena_mdr);
    end
    checks++;
    if ((ifa.mem_we && !(ifa.ack0 || ifa.ack1)) || (ifa.mem_we && ifa.ena_mdr) ||
        (ifb.mem_we && !(ifb.ack0 || ifb.ack1))) begin
      failures++;
      $display("FAIL mem_we_only_xfer: a_we=%b a_ack=%b%b b_we=%b required mem_we only with write ack", ifa.mem_we, ifa.ack0, ifa.ack1, ifb.mem_we);
    end
    checks++;
    if ((!ifa.bus_oe && ifa.bus_out !== 16'h0) || (!ifb.bus_oe && ifb.bus_out !== 16'h0)) begin
      failures++;
      $display("FAIL bus_out_idle: a=%h b=%h required 0000 when oe=0", ifa.bus_out, ifb.bus_out);
    end
  endtask

  task automatic wait_ack_a(output int port, output int lat, output logic [15:0] rd);
    port = -1;
    lat  = 0;
    rd   = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ifa.ack0 || ifa.ack1) begin
        port = ifa.ack0 ? 0 : 1;
        lat  = i;
        rd   = ifa.rdata;
        return;
      end
    end
  endtask

  task automatic idle_inputs();
    ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
    ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
    ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset    = 1'b1;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    last_served = 1;
    tick();
    tick();
    mem_init = 1'b0;
    checks++;
    if ({ifa.bus_oe, ifa.ld_mar, ifa.ld_mdr, ifa.sel_mdr, ifa.mem_we, ifa.ena_mdr,
         ifa.ack0, ifa.ack1, ifa.busy} !== 9'b0 || ifa.rdata !== 16'h0 || ifa.bus_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: oe=%b mar=%b mdr=%b we=%b ena=%b busy=%b rdata=%h required all 0",
               ifa.bus_oe, ifa.ld_mar, ifa.ld_mdr, ifa.mem_we, ifa.ena_mdr, ifa.busy, ifa.rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_p0();
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0010;
    tick();
    checks++;
    if (!(ifa.ld_mar && ifa.bus_oe && ifa.bus_out == 16'h0010 && !ifa.ld_mdr && ifa.busy)) begin
      failures++;
      $display("FAIL read_mar: ld_mar=%b oe=%b bus_out=%h required 1 1 0010", ifa.ld_mar, ifa.bus_oe, ifa.bus_out);
    end
    tick();
    checks++;
    if (!(ifa.ld_mdr && ifa.sel_mdr && !ifa.bus_oe && !ifa.ld_mar)) begin
      failures++;
      $display("FAIL read_mdr: ld_mdr=%b sel_mdr=%b oe=%b required 1 1 0", ifa.ld_mdr, ifa.sel_mdr, ifa.bus_oe);
    end
    tick();
    checks++;
    if (!(ifa.ena_mdr && ifa.ack0 && !ifa.ack1 && !ifa.mem_we) || ifa.rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_xfer: ena=%b ack0=%b ack1=%b rdata=%h required 1 1 0 beef", ifa.ena_mdr, ifa.ack0, ifa.ack1, ifa.rdata);
    end
    ifa.req0 = 0;
    last_served = 0;
    tick();
    checks++;
    if (ifa.busy || ifa.ack0 || ifa.rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL read_hold: busy=%b ack0=%b rdata=%h required 0 0 beef", ifa.busy, ifa.ack0, ifa.rdata);
    end
  endtask

  task automatic test_write_p1();
    int p, l;
    logic [15:0] rd;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 16'h0020; ifa.wdata1 = 16'h1234;
    tick();
    checks++;
    if (!(ifa.ld_mar && ifa.bus_out == 16'h0020)) begin
      failures++;
      $display("FAIL write_mar: ld_mar=%b bus_out=%h required 1 0020", ifa.ld_mar, ifa.bus_out);
    end
    tick();
    checks++;
    if (!(ifa.ld_mdr && !ifa.sel_mdr && ifa.bus_oe && ifa.bus_out == 16'h1234)) begin
      failures++;
      $display("FAIL write_mdr: ld_mdr=%b sel=%b oe=%b bus_out=%h required 1 0 1 1234", ifa.ld_mdr, ifa.sel_mdr, ifa.bus_oe, ifa.bus_out);
    end
    tick();
    checks++;
    if (!(ifa.mem_we && ifa.ack1 && !ifa.ack0 && !ifa.ena_mdr)) begin
      failures++;
      $display("FAIL write_xfer: mem_we=%b ack1=%b ack0=%b required 1 1 0", ifa.mem_we, ifa.ack1, ifa.ack0);
    end
    ifa.req1 = 0;
    ref_mem[8'h20] = 16'h1234;
    last_served = 1;
    tick();
    checks++;
    if (ifa.mem_we) begin
      failures++;
      $display("FAIL write_we_pulse: mem_we=%b required 0 after one cycle", ifa.mem_we);
    end
    ifa.req1 = 1; ifa.we1 = 0;
    wait_ack_a(p, l, rd);
    ifa.req1 = 0;
    tick();
    checks++;
    if (p != 1 || l != 3 || rd !== ref_mem[8'h20]) begin
      failures++;
      $display("FAIL write_readback: port=%0d lat=%0d rdata=%h required 1 3 %h", p, l, rd, ref_mem[8'h20]);
    end
  endtask

  task automatic test_back_to_back();
    int p, l, exp_p;
    logic [15:0] rd;
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0001;
    ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      exp_p = (last_served == 0) ? 1 : 0;
      wait_ack_a(p, l, rd);
      checks++;
      if (p != exp_p || l != ((k == 0) ? 3 : 4) || rd !== ref_mem[(exp_p == 0) ? 1 : 2]) begin
        failures++;
        $display("FAIL rr_alternate[%0d]: port=%0d lat=%0d rdata=%h required %0d %0d %h",
                 k, p, l, rd, exp_p, (k == 0) ? 3 : 4, ref_mem[(exp_p == 0) ? 1 : 2]);
      end
      last_served = exp_p;
    end
    ifa.req0 = 0; ifa.req1 = 0;
    tick();
  endtask

  task automatic test_random();
    int pat, p, l, exp_p, n_pend;
    int we_t [2];
    logic [15:0] ad_t [2];
    logic [15:0] wd_t [2];
    logic [15:0] rd;
    for (int it = 0; it < 40; it++) begin
      pat = int'($urandom_range(1, 3));
      for (int q = 0; q < 2; q++) begin
        we_t[q] = int'($urandom_range(0, 1));
        ad_t[q] = 16'($urandom_range(0, 31));
        wd_t[q] = 16'($urandom);
      end
      ifa.req0 = pat[0]; ifa.we0 = we_t[0][0]; ifa.addr0 = ad_t[0]; ifa.wdata0 = wd_t[0];
      ifa.req1 = pat[1]; ifa.we1 = we_t[1][0]; ifa.addr1 = ad_t[1]; ifa.wdata1 = wd_t[1];
      n_pend = (pat == 3) ? 2 : 1;
      for (int s = 0; s < n_pend; s++) begin
        if (pat == 3) exp_p = (last_served == 0) ? 1 : 0;
        else          exp_p = (pat == 1) ? 0 : 1;
        wait_ack_a(p, l, rd);
        checks++;
        if (p != exp_p || l != ((s == 0) ? 3 : 4) ||
            (we_t[exp_p] == 0 && rd !== ref_mem[ad_t[exp_p][7:0]])) begin
          failures++;
          $display("FAIL random[%0d.%0d]: port=%0d lat=%0d rdata=%h required %0d %0d %h (we=%0d)",
                   it, s, p, l, rd, exp_p, (s == 0) ? 3 : 4, ref_mem[ad_t[exp_p][7:0]], we_t[exp_p]);
        end
        if (we_t[exp_p] != 0) ref_mem[ad_t[exp_p][7:0]] = wd_t[exp_p];
        last_served = exp_p;
        if (exp_p == 0) ifa.req0 = 0; else ifa.req1 = 0;
        pat = pat & ~(1 << exp_p);
      end
      tick();
    end
  endtask

  task automatic test_wait_states();
    int idle_ok, l;
    ifb.req0 = 1; ifb.we0 = 0; ifb.addr0 = 16'h0030;
    tick();
    checks++;
    if (!(ifb.ld_mar && ifb.bus_out == 16'h0030)) begin
      failures++;
      $display("FAIL wait_mar: ld_mar=%b bus_out=%h required 1 0030", ifb.ld_mar, ifb.bus_out);
    end
    idle_ok = 0;
    for (int w = 0; w < 3; w++) begin
      tick();
      if (!ifb.bus_oe && !ifb.ld_mar && !ifb.ld_mdr && !ifb.sel_mdr && !ifb.mem_we &&
          !ifb.ena_mdr && !ifb.ack0 && ifb.busy) idle_ok++;
    end
    checks++;
    if (idle_ok != 3) begin
      failures++;
      $display("FAIL wait_quiet: quiet_cycles=%0d required 3", idle_ok);
    end
    tick();
    checks++;
    if (!(ifb.ld_mdr && ifb.sel_mdr)) begin
      failures++;
      $display("FAIL wait_mdr: ld_mdr=%b sel_mdr=%b required 1 1 at cycle 5", ifb.ld_mdr, ifb.sel_mdr);
    end
    l = 5;
    tick();
    l++;
    checks++;
    if (!(ifb.ack0 && ifb.ena_mdr) || ifb.rdata !== 16'hA5C3) begin
      failures++;
      $display("FAIL wait_ack: cycle=%0d ack0=%b ena=%b rdata=%h required ack at 6 rdata a5c3", l, ifb.ack0, ifb.ena_mdr, ifb.rdata);
    end
    ifb.req0 = 0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int p, l, exp_p;
    logic [15:0] rd;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 16'h0040; ifa.wdata1 = 16'hDEAD;
    tick();
    tick();
    checks++;
    if (!(ifa.ld_mdr && ifa.bus_oe && ifa.bus_out == 16'hDEAD)) begin
      failures++;
      $display("FAIL abort_setup: ld_mdr=%b oe=%b bus_out=%h required 1 1 dead", ifa.ld_mdr, ifa.bus_oe, ifa.bus_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.bus_oe, ifa.ld_mar, ifa.ld_mdr, ifa.sel_mdr, ifa.mem_we, ifa.ena_mdr,
         ifa.ack0, ifa.ack1, ifa.busy} !== 9'b0) begin
      failures++;
      $display("FAIL abort_immediate: oe=%b ld_mdr=%b mem_we=%b ack=%b%b busy=%b required all 0",
               ifa.bus_oe, ifa.ld_mdr, ifa.mem_we, ifa.ack0, ifa.ack1, ifa.busy);
    end
    ifa.req1 = 0;
    last_served = 1;
    tick();
    reset = 1'b0;
    tick();
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0040;
    ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 16'h0041;
    exp_p = 0;
    wait_ack_a(p, l, rd);
    checks++;
    if (p != exp_p || l != 3 || rd !== ref_mem[8'h40]) begin
      failures++;
      $display("FAIL abort_tie_and_mem: port=%0d lat=%0d rdata=%h required 0 3 %h", p, l, rd, ref_mem[8'h40]);
    end
    ifa.req0 = 0;
    wait_ack_a(p, l, rd);
    checks++;
    if (p != 1 || rd !== ref_mem[8'h41]) begin
      failures++;
      $display("FAIL abort_second: port=%0d rdata=%h required 1 %h", p, rd, ref_mem[8'h41]);
    end
    ifa.req1 = 0;
    last_served = 1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read_p0();
    test_write_p1();
    test_back_to_back();
    test_random();
    test_wait_states();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer and two-port arbiter for the MAR/MDR memory datapath on the shared 16-bit bus. It accepts read/write requests from port 0 (instruction fetch) and port 1 (data access). It grants one request at a time, round-robin on ties. It generates the bus drive and the memory strobes for the grant: ld_mar, ld_mdr, sel_mdr, mem_we and ena_mdr. Read data is captured off the bus and returned with a one-cycle ack.

Parameters:
DW, 16, data/address width (must match bus and MAR/MDR width)
MEM_WAIT, 0, extra wait cycles between MAR load and MDR load (0..15)

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  asynchronous, active-high
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  DW  port 0 address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 completion pulse, 1 cycle
req1/we1/addr1/wdata1  in  1/1/DW/DW  port 1, same meaning
ack1  out  1  port 1 completion pulse
rdata  out  DW  read data; valid in the ack cycle, held until next read completes
bus_in  in  DW  resolved shared bus value
bus_out  out  DW  value this block drives onto bus
bus_oe  out  1  tristate enable for bus_out
ld_mar, ld_mdr, sel_mdr, mem_we, ena_mdr  out  1 each  memory datapath strobes
busy  out  1  high in every non-IDLE state

Behaviour:
- Reset (async): state=IDLE, all outputs 0, rdata=0, RR pointer favours port 0.
- Reset mid-transaction aborts immediately: no ack, no mem_we.
- All strobes and bus_oe are decoded from registered state and latched transaction regs (Moore); no combinational path from req to strobes.
- IDLE: if any req is high, arbitrate, then latch sel_port, we, addr and wdata into internal regs; next state MAR. Requester inputs are ignored after grant.
- Arbitration:
  - Single request wins.
  - Both requesting: the port not served last wins.
  - After reset, port 0 wins the first tie.
  - Pointer updates at grant.
- MAR: bus_oe=1, bus_out=addr, ld_mar=1. Next: WAIT if MEM_WAIT>0, else MDR.
- WAIT: counter loads MEM_WAIT-1 on entry and decrements each cycle; leave to MDR when it reaches 0. All strobes 0.
- MDR:
  - Read: ld_mdr=1, sel_mdr=1, bus_oe=0.
  - Write: ld_mdr=1, sel_mdr=0, bus_oe=1, bus_out=wdata.
  - Next: XFER.
- XFER:
  - Read: ena_mdr=1, rdata<=bus_in at clock edge, ack of granted port=1.
  - Write: mem_we=1, ack=1.
  - Next: IDLE.
- Latency: req seen in IDLE at cycle 0 -> ack in cycle 3+MEM_WAIT. Throughput: one transaction per 4+MEM_WAIT cycles (mandatory IDLE cycle between transactions).
- bus_oe is never 1 in the same cycle as ena_mdr.
- bus_out=0 whenever bus_oe=0.
- Requester dropping req before ack is a protocol violation: the latched transaction still completes and ack still pulses.
- Request asserted during a busy transaction waits; it is evaluated in the next IDLE.
- ack0 and ack1 are never high together.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum {IDLE, MAR, WAIT, MDR, XFER}.
  - DW default and MEM_WAIT max constant.
  - Port index typedef.
- Sub-module rr_arbiter2: two requests, enable, registered last-grant pointer, one-hot grant out. Arbitration only.

Test Plan:
- Reset, then port 0 read addr=0x0010, memory[0x10]=0xBEEF, MEM_WAIT=0 -> ld_mar cycle 1 with bus_out=0x0010, ld_mdr+sel_mdr cycle 2, ena_mdr+ack0 cycle 3, rdata=0xBEEF.
- Port 1 write addr=0x0020 data=0x1234, then port 1 read 0x0020 -> sel_mdr=0 with bus_out=0x1234 in MDR, mem_we one cycle, read returns 0x1234.
- req0 and req1 both held continuously, reads of 0x01/0x02 -> acks alternate ack0, ack1, ack0, ack1, each 4 cycles apart, port 0 first.
- MEM_WAIT=3 read -> exactly 3 cycles with all strobes 0 between ld_mar and ld_mdr; ack at cycle 6.
- reset asserted during MDR of a write -> all strobes 0 immediately, no mem_we, no ack, memory unchanged, next tie goes to port 0.
- Assertions every cycle: at most one of ack0/ack1; bus_oe and ena_mdr never both 1; mem_we only in XFER of a write.
